// File: rtl/led_sweep_fsm.sv
// Single lit LED walking across NLEDS outputs (bounce / wrap-left / wrap-right / hold).
// Optional build macro LED_SWEEP_TRAIL_EN adds a one-step trail LED.
module led_sweep_fsm #(
  parameter int NLEDS   = 8,
  parameter int CLK_DIV = 4,
  localparam int PW     = $clog2(NLEDS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_display_enable,
  input  logic [1:0]       i_mode,
  output logic [NLEDS-1:0] o_led,
  output logic [PW-1:0]    o_pos,
  output logic             o_dir,
  output logic             o_step,
  output logic             o_wrap
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(NLEDS - 1);

  typedef enum logic {S_UP = 1'b0, S_DOWN = 1'b1} dir_t;
  typedef enum logic [1:0] {M_BOUNCE = 2'd0, M_LEFT = 2'd1, M_RIGHT = 2'd2, M_HOLD = 2'd3} mode_t;

  mode_t         mode;
  dir_t          state;
  logic [CW-1:0] presc;
  logic          tick;
`ifdef LED_SWEEP_TRAIL_EN
  logic [PW-1:0] prev_pos;
`endif

  assign mode  = mode_t'(i_mode);
  assign tick  = i_enable && (mode != M_HOLD) && (presc == DIV_LAST);
  assign o_dir = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc  <= '0;
      state  <= S_UP;
      o_pos  <= '0;
      o_step <= 1'b0;
      o_wrap <= 1'b0;
`ifdef LED_SWEEP_TRAIL_EN
      prev_pos <= '0;
`endif
    end else begin
      o_step <= tick;
      o_wrap <= 1'b0;
      if (i_enable) begin
        if (mode == M_HOLD || tick) presc <= '0;
        else                        presc <= presc + 1'b1;
      end
      if (tick) begin
`ifdef LED_SWEEP_TRAIL_EN
        prev_pos <= o_pos;
`endif
        case (mode)
          M_BOUNCE: begin
            if (state == S_UP) begin
              if (o_pos == POS_LAST) begin
                o_pos  <= POS_LAST - 1'b1;
                state  <= S_DOWN;
                o_wrap <= 1'b1;
              end else begin
                o_pos <= o_pos + 1'b1;
              end
            end else begin
              if (o_pos == '0) begin
                o_pos  <= PW'(1);
                state  <= S_UP;
                o_wrap <= 1'b1;
              end else begin
                o_pos <= o_pos - 1'b1;
              end
            end
          end
          M_LEFT: begin
            state <= S_UP;
            if (o_pos == POS_LAST) begin
              o_pos  <= '0;
              o_wrap <= 1'b1;
            end else begin
              o_pos <= o_pos + 1'b1;
            end
          end
          M_RIGHT: begin
            state <= S_DOWN;
            if (o_pos == '0) begin
              o_pos  <= POS_LAST;
              o_wrap <= 1'b1;
            end else begin
              o_pos <= o_pos - 1'b1;
            end
          end
          M_HOLD: ;
        endcase
      end
    end
  end

  // Display gating is deliberately combinational so blanking takes effect the same cycle.
  always_comb begin
    o_led = '0;
    for (int unsigned i = 0; i < NLEDS; i++) begin
      o_led[i] = (o_pos == PW'(i));
`ifdef LED_SWEEP_TRAIL_EN
      if (prev_pos == PW'(i)) o_led[i] = 1'b1;
`endif
    end
    if (!i_display_enable) o_led = '0;
  end

endmodule

// File: tb/tb_led_sweep_fsm.sv
// Scoreboard bench for led_sweep_fsm: three instances (8/1, 8/4, 5/1), directed expectations.
module tb_led_sweep_fsm;

  typedef struct {
    logic [2:0] pos;
    logic       dir;
    logic       wrap;
    logic [7:0] led;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  exp_t qa[$], qb[$], qc[$];
  int   cur[3] = '{0, 0, 0};
  int   prv[3] = '{0, 0, 0};
  int   b_t0 = 0;

  logic       rst_a = 1'b0, en_a = 1'b0, disp_a = 1'b1;
  logic       rst_b = 1'b0, en_b = 1'b0, disp_b = 1'b1;
  logic       rst_c = 1'b0, en_c = 1'b0, disp_c = 1'b1;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0, mode_c = 2'd0;

  logic [7:0] o_led_a, o_led_b;
  logic [4:0] o_led_c;
  logic [2:0] o_pos_a, o_pos_b, o_pos_c;
  logic       o_dir_a, o_dir_b, o_dir_c;
  logic       o_step_a, o_step_b, o_step_c;
  logic       o_wrap_a, o_wrap_b, o_wrap_c;

  led_sweep_fsm #(.NLEDS(8), .CLK_DIV(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_enable(en_a), .i_display_enable(disp_a), .i_mode(mode_a),
    .o_led(o_led_a), .o_pos(o_pos_a), .o_dir(o_dir_a), .o_step(o_step_a), .o_wrap(o_wrap_a));
  led_sweep_fsm #(.NLEDS(8), .CLK_DIV(4)) u_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_enable(en_b), .i_display_enable(disp_b), .i_mode(mode_b),
    .o_led(o_led_b), .o_pos(o_pos_b), .o_dir(o_dir_b), .o_step(o_step_b), .o_wrap(o_wrap_b));
  led_sweep_fsm #(.NLEDS(5), .CLK_DIV(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_c), .i_enable(en_c), .i_display_enable(disp_c), .i_mode(mode_c),
    .o_led(o_led_c), .o_pos(o_pos_c), .o_dir(o_dir_c), .o_step(o_step_c), .o_wrap(o_wrap_c));

  // Directed expectation tables (bounce runs from reset).
  int a_pos[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int a_dir[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  int a_wrp[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
  int c_pos[16] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0};
  int c_dir[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
  int c_wrp[16] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] led_f(input int p, input int q);
    logic [7:0] v;
    v = '0;
    v[p] = 1'b1;
`ifdef LED_SWEEP_TRAIL_EN
    v[q] = 1'b1;
`endif
    return v;
  endfunction

  task automatic push(input int d, input int p, input int dr, input int w, input int cy);
    exp_t e;
    prv[d] = cur[d];
    cur[d] = p;
    e.pos  = 3'(p);
    e.dir  = dr[0];
    e.wrap = w[0];
    e.led  = led_f(cur[d], prv[d]);
    e.cyc  = cy;
    case (d)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // Monitors: each step pulse pops one expected step outcome.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (o_wrap_a && !o_step_a) check("a_wrap_without_step", o_wrap_a, 0);
    if (o_step_a === 1'b1) begin
      if (qa.size() == 0) check("a_spurious_step", o_step_a, 0);
      else begin
        e = qa.pop_front();
        check("a_pos", o_pos_a, e.pos);
        check("a_dir", o_dir_a, e.dir);
        check("a_wrap", o_wrap_a, e.wrap);
        if (disp_a) check("a_led", o_led_a, e.led);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (o_wrap_b && !o_step_b) check("b_wrap_without_step", o_wrap_b, 0);
    if (o_step_b === 1'b1) begin
      if (qb.size() == 0) check("b_spurious_step", o_step_b, 0);
      else begin
        e = qb.pop_front();
        check("b_step_cycle", cyc - b_t0, e.cyc);
        check("b_pos", o_pos_b, e.pos);
        check("b_dir", o_dir_b, e.dir);
        check("b_wrap", o_wrap_b, e.wrap);
        check("b_led", o_led_b, e.led);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (o_step_c === 1'b1) begin
      check("c_pos_range", o_pos_c <= 3'd4, 1);
      if (qc.size() == 0) check("c_spurious_step", o_step_c, 0);
      else begin
        e = qc.pop_front();
        check("c_pos", o_pos_c, e.pos);
        check("c_dir", o_dir_c, e.dir);
        check("c_wrap", o_wrap_c, e.wrap);
        check("c_led", {3'b000, o_led_c}, e.led);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("a_rst_pos", o_pos_a, 0);
    check("a_rst_dir", o_dir_a, 0);
    check("a_rst_step", o_step_a, 0);
    check("a_rst_wrap", o_wrap_a, 0);
    check("a_rst_led", o_led_a, 8'h01);
    check("b_rst_pos", o_pos_b, 0);
    check("c_rst_led", o_led_c, 5'h01);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);

    // Bounce at one step per cycle: full 14-step period plus one.
    for (int i = 0; i < 15; i++) push(0, a_pos[i], a_dir[i], a_wrp[i], 0);
    en_a = 1'b1;
    repeat (15) @(negedge clk);
    en_a = 1'b0;

    // Display gating is immediate and leaves position untouched.
    @(negedge clk);
    disp_a = 1'b0;
    #1 check("a_gated_led", o_led_a, 0);
    check("a_gated_pos", o_pos_a, 1);
    disp_a = 1'b1;
    #1 check("a_ungated_led", o_led_a, led_f(cur[0], prv[0]));

    // Wrap-left from 1 through 7->0, then wrap-right 1,0,7,6, then hold.
    @(negedge clk);
    mode_a = 2'd1;
    for (int p = 2; p <= 7; p++) push(0, p, 0, 0, 0);
    push(0, 0, 0, 1, 0);
    push(0, 1, 0, 0, 0);
    en_a = 1'b1;
    repeat (8) @(negedge clk);
    mode_a = 2'd2;
    push(0, 0, 1, 0, 0);
    push(0, 7, 1, 1, 0);
    push(0, 6, 1, 0, 0);
    repeat (3) @(negedge clk);
    mode_a = 2'd3;
    repeat (20) @(negedge clk);
    check("a_hold_pos", o_pos_a, 6);
    check("a_hold_dir", o_dir_a, 1);
    check("a_hold_step", o_step_a, 0);

    // Bounce keeps the current DOWN direction; then async reset mid-pulse.
    mode_a = 2'd0;
    push(0, 5, 1, 0, 0);
    @(negedge clk);
    en_a = 1'b0;
    #1 rst_a = 1'b0;
    #1 check("a_async_pos", o_pos_a, 0);
    check("a_async_dir", o_dir_a, 0);
    check("a_async_step", o_step_a, 0);
    check("a_async_wrap", o_wrap_a, 0);
    check("a_async_led", o_led_a, 8'h01);
    cur[0] = 0; prv[0] = 0;
    @(negedge clk);
    rst_a = 1'b1;

    // Prescaler of 4: freeze for 10 cycles, resume without skip, hold clears count.
    push(1, 1, 0, 0, 4);
    push(1, 2, 0, 0, 8);
    push(1, 3, 0, 0, 22);
    push(1, 4, 0, 0, 26);
    push(1, 5, 0, 0, 51);
    @(negedge clk);
    en_b = 1'b1;
    b_t0 = cyc;
    repeat (10) @(negedge clk);
    en_b = 1'b0;
    repeat (10) @(negedge clk);
    check("b_frozen_pos", o_pos_b, 2);
    check("b_frozen_step", o_step_b, 0);
    en_b = 1'b1;
    repeat (7) @(negedge clk);
    mode_b = 2'd3;
    repeat (20) @(negedge clk);
    mode_b = 2'd0;
    repeat (4) @(negedge clk);
    en_b = 1'b0;

    // Non-power-of-two width bounce.
    for (int i = 0; i < 16; i++) push(2, c_pos[i], c_dir[i], c_wrp[i], 0);
    @(negedge clk);
    en_c = 1'b1;
    repeat (16) @(negedge clk);
    en_c = 1'b0;

    repeat (4) @(negedge clk);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("qc_drained", qc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
